vx_perf_cache_sampler: RTL and testbench

//  Consumer (slave) end of the cache perf-counter bundle: snapshots all nine live cache counters

---
 rtl/VX_perf_pkg.sv | 21 ++
 rtl/VX_perf_cache_if.sv | 16 +
 rtl/vx_perf_rsp_buf.sv | 23 ++
 rtl/vx_perf_cache_sampler.sv | 89 ++++++++
 tb/tb_vx_perf_cache_sampler.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/VX_perf_pkg.sv
// VX_perf_pkg: shared constants and types for the cache perf-counter sampler
package VX_perf_pkg;
  localparam int NUM_CACHE_CTRS = 9;
  localparam logic [3:0] STATUS_IDX = 4'd15;
  localparam int ADDR_DELTA_BIT = 5;
  localparam int ADDR_IDX_HI = 4;
  localparam int ADDR_IDX_LO = 1;
  localparam int ADDR_HI_BIT = 0;
  typedef enum logic [3:0] {
    CTR_READS = 4'd0,
    CTR_WRITES = 4'd1,
    CTR_READ_MISSES = 4'd2,
    CTR_WRITE_MISSES = 4'd3,
    CTR_BANK_STALLS = 4'd4,
    CTR_MSHR_STALLS = 4'd5,
    CTR_PIPE_STALLS = 4'd6,
    CTR_CRSP_STALLS = 4'd7,
    CTR_PREFETCH = 4'd8
  } ctr_idx_e;
  typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} sampler_state_e;
endpackage

// File: rtl/VX_perf_cache_if.sv
// VX_perf_cache_if: bundle of the nine live cache perf counters
interface VX_perf_cache_if #(parameter int CTR_BITS = 44);
  logic [CTR_BITS-1:0] reads;
  logic [CTR_BITS-1:0] writes;
  logic [CTR_BITS-1:0] read_misses;
  logic [CTR_BITS-1:0] write_misses;
  logic [CTR_BITS-1:0] bank_stalls;
  logic [CTR_BITS-1:0] mshr_stalls;
  logic [CTR_BITS-1:0] pipe_stalls;
  logic [CTR_BITS-1:0] crsp_stalls;
  logic [CTR_BITS-1:0] prefetch_requests;
  modport master (output reads, writes, read_misses, write_misses, bank_stalls,
                  mshr_stalls, pipe_stalls, crsp_stalls, prefetch_requests);
  modport slave (input reads, writes, read_misses, write_misses, bank_stalls,
                 mshr_stalls, pipe_stalls, crsp_stalls, prefetch_requests);
endinterface

// File: rtl/vx_perf_rsp_buf.sv
// vx_perf_rsp_buf: one-entry valid/ready output register holding data until accepted
module vx_perf_rsp_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk)
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data <= in_data;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: rtl/vx_perf_cache_sampler.sv
// vx_perf_cache_sampler: atomic snapshot of cache perf counters served as raw/delta CSR reads
module vx_perf_cache_sampler
  import VX_perf_pkg::*;
#(
  parameter int CTR_BITS = 44
) (
  input  logic                 clk,
  input  logic                 reset,
  VX_perf_cache_if.slave       perf_cache_if,
  input  logic                 snap_valid,
  output logic                 snap_ready,
  output logic                 snap_done,
  input  logic                 clear,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [5:0]           req_addr,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err
);
  logic [CTR_BITS-1:0] live [NUM_CACHE_CTRS];
  logic [CTR_BITS-1:0] shadow [NUM_CACHE_CTRS];
  logic [CTR_BITS-1:0] prev [NUM_CACHE_CTRS];
  logic [NUM_CACHE_CTRS-1:0] wrap;
  logic snap_taken;
  sampler_state_e state;
  logic buf_ready;
  logic [3:0] idx;
  logic [3:0] sel;
  logic is_ctr;
  logic [CTR_BITS-1:0] v;
  logic [63:0] v64;
  logic [32:0] pay;
  logic [32:0] rsp_pay;
  assign live[0] = perf_cache_if.reads;
  assign live[1] = perf_cache_if.writes;
  assign live[2] = perf_cache_if.read_misses;
  assign live[3] = perf_cache_if.write_misses;
  assign live[4] = perf_cache_if.bank_stalls;
  assign live[5] = perf_cache_if.mshr_stalls;
  assign live[6] = perf_cache_if.pipe_stalls;
  assign live[7] = perf_cache_if.crsp_stalls;
  assign live[8] = perf_cache_if.prefetch_requests;
  assign snap_ready = state == IDLE;
  assign req_ready = state == IDLE && buf_ready;
  assign idx = req_addr[ADDR_IDX_HI:ADDR_IDX_LO];
  assign is_ctr = idx <= CTR_PREFETCH;
  assign sel = is_ctr ? idx : CTR_READS;
  assign v = req_addr[ADDR_DELTA_BIT] ? shadow[sel] - prev[sel] : shadow[sel];
  assign v64 = 64'(v);
  // payload is {err, data}; status ignores the delta bit
  assign pay = idx == STATUS_IDX ? {1'b0, req_addr[ADDR_HI_BIT] ? 32'd0 : {snap_taken, 22'd0, wrap}}
             : is_ctr ? {1'b0, req_addr[ADDR_HI_BIT] ? v64[63:32] : v64[31:0]}
             : {1'b1, 32'd0};
  assign rsp_err = rsp_pay[32];
  assign rsp_data = rsp_pay[31:0];
  always_ff @(posedge clk)
    if (reset || clear) begin
      state <= IDLE;
      snap_done <= 1'b0;
      snap_taken <= 1'b0;
      wrap <= '0;
      for (int i = 0; i < NUM_CACHE_CTRS; i++) begin
        shadow[i] <= '0;
        prev[i] <= '0;
      end
    end else begin
      snap_done <= state == CAPTURE;
      state <= state == IDLE ? (snap_valid ? CAPTURE : IDLE) : state == CAPTURE ? COMMIT : IDLE;
      if (state == CAPTURE)
        for (int i = 0; i < NUM_CACHE_CTRS; i++) begin
          prev[i] <= shadow[i];
          shadow[i] <= live[i];
          wrap[i] <= wrap[i] | (live[i] < shadow[i]);
        end
      if (state == COMMIT) snap_taken <= 1'b1;
    end
  vx_perf_rsp_buf #(.W(33)) u_rsp_buf (
    .clk(clk),
    .reset(reset),
    .in_valid(req_valid && req_ready),
    .in_ready(buf_ready),
    .in_data(pay),
    .out_valid(rsp_valid),
    .out_ready(rsp_ready),
    .out_data(rsp_pay)
  );
endmodule

// File: tb/tb_vx_perf_cache_sampler.sv
// tb_vx_perf_cache_sampler: directed tests of snapshot, delta, wrap, clear and rsp backpressure
module tb_vx_perf_cache_sampler;
  localparam int CB = 44;
  logic clk = 0;
  logic reset = 1;
  logic snap_valid = 0, snap_ready, snap_done, clear = 0;
  logic req_valid = 0, req_ready, rsp_valid, rsp_ready = 1, rsp_err;
  logic [5:0] req_addr = 0;
  logic [31:0] rsp_data;
  int checks = 0, errors = 0;
  VX_perf_cache_if #(.CTR_BITS(CB)) pif ();
  vx_perf_cache_sampler #(.CTR_BITS(CB)) dut (
    .clk(clk), .reset(reset), .perf_cache_if(pif), .snap_valid(snap_valid),
    .snap_ready(snap_ready), .snap_done(snap_done), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  task automatic rd(input logic [5:0] a, output logic v, output logic [31:0] d, output logic e);
    req_valid = 1; req_addr = a; rsp_ready = 1;
    @(negedge clk);
    v = rsp_valid; d = rsp_data; e = rsp_err;
    req_valid = 0;
    @(negedge clk);
  endtask
  task automatic snap(output int n);
    n = 0;
    snap_valid = 1;
    for (int i = 1; i <= 8 && n == 0; i++) begin
      @(negedge clk);
      snap_valid = 0;
      if (snap_done) n = i;
    end
    @(negedge clk);
  endtask
  task automatic test_reset;
    logic v, e; logic [31:0] d;
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    checks++; if (snap_ready !== 1'b1 || snap_done !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL reset_ctl: ready=%b done=%b req_ready=%b, need 1 0 1", snap_ready, snap_done, req_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: v=%b d=%h e=%b, need 0 0 0", rsp_valid, rsp_data, rsp_err); end
    rd(6'h00, v, d, e);
    checks++; if (v !== 1'b1 || d !== 32'd0 || e !== 1'b0) begin errors++; $display("FAIL reset_rd0: v=%b d=%h e=%b, need 1 0 0", v, d, e); end
    rd(6'h1E, v, d, e);
    checks++; if (d !== 32'd0 || e !== 1'b0) begin errors++; $display("FAIL reset_status: d=%h e=%b, need 0 0", d, e); end
  endtask
  task automatic test_snap_raw;
    logic v, e; logic [31:0] d; int n;
    pif.reads = 44'h1_0000_0005;
    snap(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL snap_latency: got %0d, need 2", n); end
    rd(6'h00, v, d, e);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL raw_lo: got %h, need 5", d); end
    rd(6'h01, v, d, e);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL raw_hi: got %h, need 1", d); end
  endtask
  task automatic test_delta;
    logic v, e; logic [31:0] d; int n;
    pif.reads = 44'h1_0000_0009;
    snap(n);
    rd(6'h20, v, d, e);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL delta_lo: got %h, need 4", d); end
    rd(6'h21, v, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL delta_hi: got %h, need 0", d); end
    rd(6'h00, v, d, e);
    checks++; if (d !== 32'h9) begin errors++; $display("FAIL raw2_lo: got %h, need 9", d); end
    rd(6'h1E, v, d, e);
    checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL status_taken: got %h, need 80000000", d); end
  endtask
  task automatic test_wrap_clear;
    logic v, e; logic [31:0] d; int n;
    pif.writes = 44'hFFF_FFFF_FFF0;
    snap(n);
    pif.writes = 44'h10;
    snap(n);
    rd(6'h22, v, d, e);
    checks++; if (d !== 32'h20) begin errors++; $display("FAIL wrap_delta_lo: got %h, need 20", d); end
    rd(6'h23, v, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_delta_hi: got %h, need 0", d); end
    rd(6'h3E, v, d, e);
    checks++; if (d !== 32'h8000_0002) begin errors++; $display("FAIL wrap_status: got %h, need 80000002", d); end
    clear = 1;
    @(negedge clk);
    clear = 0;
    rd(6'h1E, v, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_status: got %h, need 0", d); end
    rd(6'h00, v, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_raw: got %h, need 0", d); end
    rd(6'h22, v, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_delta: got %h, need 0", d); end
  endtask
  task automatic test_backpressure;
    int n;
    pif.reads = 44'h1234;
    snap(n);
    rsp_ready = 0; req_valid = 1; req_addr = 6'h00;
    @(negedge clk);
    req_addr = 6'h18;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234 || req_ready !== 1'b0) begin errors++; $display("FAIL hold_%0d: v=%b d=%h req_ready=%b, need 1 1234 0", i, rsp_valid, rsp_data, req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'd0) begin errors++; $display("FAIL bad_idx: v=%b e=%b d=%h, need 1 1 0", rsp_valid, rsp_err, rsp_data); end
    req_addr = 6'h00;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h1234) begin errors++; $display("FAIL b2b_0: v=%b e=%b d=%h, need 1 0 1234", rsp_valid, rsp_err, rsp_data); end
    req_addr = 6'h1E;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h8000_0000) begin errors++; $display("FAIL b2b_1: v=%b d=%h, need 1 80000000", rsp_valid, rsp_data); end
    req_valid = 0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain: v=%b, need 0", rsp_valid); end
  endtask
  task automatic test_clear_race_reset;
    logic v, e; logic [31:0] d; int pulses;
    pif.reads = 44'h77;
    snap_valid = 1; clear = 1;
    @(negedge clk);
    snap_valid = 0; clear = 0;
    pulses = 0;
    checks++; if (snap_ready !== 1'b1) begin errors++; $display("FAIL race_idle: snap_ready=%b, need 1", snap_ready); end
    repeat (3) begin
      if (snap_done) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL race_pulse: got %0d pulses, need 0", pulses); end
    rd(6'h00, v, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL race_shadow: got %h, need 0", d); end
    snap_valid = 1;
    @(negedge clk);
    snap_valid = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    pulses = 0;
    checks++; if (snap_ready !== 1'b1) begin errors++; $display("FAIL rst_idle: snap_ready=%b, need 1", snap_ready); end
    repeat (3) begin
      if (snap_done) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_pulse: got %0d pulses, need 0", pulses); end
    rd(6'h00, v, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_shadow: got %h, need 0", d); end
  endtask
  initial begin
    pif.reads = 0; pif.writes = 0; pif.read_misses = 0; pif.write_misses = 0;
    pif.bank_stalls = 0; pif.mshr_stalls = 0; pif.pipe_stalls = 0;
    pif.crsp_stalls = 0; pif.prefetch_requests = 0;
    @(negedge clk);
    test_reset;
    test_snap_raw;
    test_delta;
    test_wrap_clear;
    test_backpressure;
    test_clear_race_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
